// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons that all see one broadcast input stream.
// Each accepted sample is one step. The step's spike vector sits in a valid/ready output register.
module lif_neuron_array #(
  parameter int N_NEURONS     = 4,
  parameter int DATA_W        = 8,
  parameter int REFRACT_STEPS = 2,
  localparam int IDX_W        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
  localparam int CNT_W        = $clog2(N_NEURONS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [1:0]           cfg_field,
  input  logic [DATA_W-1:0]    cfg_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_NEURONS-1:0] out_spikes,
  output logic [CNT_W-1:0]     out_count
);

  localparam int RC_W = (REFRACT_STEPS > 0) ? $clog2(REFRACT_STEPS + 1) : 1;

  logic                 step;
  logic                 out_valid_q;
  logic [N_NEURONS-1:0] out_spikes_q;
  logic [CNT_W-1:0]     out_count_q;
  logic [N_NEURONS-1:0] spike_d;
  logic [CNT_W-1:0]     count_d;

  assign in_ready   = !out_valid_q || out_ready;
  assign step       = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign out_spikes = out_spikes_q;
  assign out_count  = out_count_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
      logic [DATA_W-1:0] v_q, v_d;
      logic [DATA_W-1:0] leak_q, thresh_q, weight_q;
      logic [RC_W-1:0]   rc_q, rc_d;
      logic [DATA_W-1:0] contrib;
      logic [DATA_W-1:0] v_leak;
      logic [DATA_W:0]   v_sum;
      logic [DATA_W-1:0] v_new;
      logic              fire;
      logic              cfg_hit;

      // The full-width product is kept before taking its upper half, so the weight acts as a fraction of 1.0.
      assign contrib = DATA_W'(({{DATA_W{1'b0}}, in_data} * {{DATA_W{1'b0}}, weight_q}) >> DATA_W);
      assign v_leak  = (v_q > leak_q) ? (v_q - leak_q) : '0;
      assign v_sum   = {1'b0, v_leak} + {1'b0, contrib};
      assign v_new   = v_sum[DATA_W] ? '1 : v_sum[DATA_W-1:0];
      assign fire    = (rc_q == '0) && (thresh_q != '0) && (v_new >= thresh_q);
      assign cfg_hit = cfg_we && (cfg_idx == IDX_W'(gi));

      always_comb begin
        v_d  = v_q;
        rc_d = rc_q;
        if (step) begin
          if (rc_q != '0) begin
            v_d  = '0;
            rc_d = rc_q - RC_W'(1);
          end else if (fire) begin
            v_d  = '0;
            rc_d = RC_W'(REFRACT_STEPS);
          end else begin
            v_d = v_new;
          end
        end
        // A clear in the same cycle as a step overrides the step's update of v/rc.
        if (cfg_hit && (cfg_field == 2'd3)) begin
          v_d  = '0;
          rc_d = '0;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          v_q      <= '0;
          rc_q     <= '0;
          leak_q   <= '0;
          weight_q <= '0;
          thresh_q <= '1;
        end else begin
          v_q  <= v_d;
          rc_q <= rc_d;
          if (cfg_hit) begin
            case (cfg_field)
              2'd0:    leak_q   <= cfg_data;
              2'd1:    thresh_q <= cfg_data;
              2'd2:    weight_q <= cfg_data;
              default: ;
            endcase
          end
        end
      end

      assign spike_d[gi] = step && fire;
    end
  endgenerate

  always_comb begin
    count_d = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      count_d = count_d + CNT_W'(spike_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      out_spikes_q <= '0;
      out_count_q  <= '0;
    end else if (step) begin
      out_valid_q  <= 1'b1;
      out_spikes_q <= spike_d;
      out_count_q  <= count_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
